io_bus_initiator: RTL and testbench
===================================

// Module: io_bus_initiator
// PURPOSE
//   Initiator for the 4-bit-address / 8-bit-data I/O register bus of the on-board I/O block
//   (switches, buttons, LEDs, DPs, 7-seg display regs 0x0-0xF).
//   Queues read/write commands from a valid/ready host port and drives addr/re/we/wdata with
//   registered strobes. Samples read data and returns it on a valid/ready response port.
//   Allows a UART bridge or test sequencer to share the peripheral bus with the CPU.
// PARAMETERS
//   DEPTH    4  command FIFO entries; power of 2, >=2
//   RD_WAIT  1  cycles bus_re held before bus_rdata is sampled; >=1
// PORTS
//   clk        in   1  system clock (100MHz)
//   rst_n      in   1  asynchronous, active-low reset
//   cmd_valid  in   1  host command valid
//   cmd_ready  out  1  FIFO can accept a command
//   cmd_write  in   1  1 = write, 0 = read
//   cmd_addr   in   4  register address
//   cmd_wdata  in   8  write data; ignored for reads
//   rsp_valid  out  1  read response valid
//   rsp_ready  in   1  host accepts response
//   rsp_addr   out  4  address of the responded command
//   rsp_rdata  out  8  sampled read data
//   rsp_err    out  1  verify mismatch; constant 0 without IO_WRITE_VERIFY_EN
//   bus_addr   out  4  to peripheral addr
//   bus_re     out  1  to peripheral re
//   bus_we     out  1  to peripheral we
//   bus_wdata  out  8  to peripheral data_in
//   bus_rdata  in   8  from peripheral data_out (combinational in the responder)
//   busy       out  1  FIFO non-empty or FSM not IDLE
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - all outputs 0 except cmd_ready = 1; FIFO emptied; FSM = IDLE.
//   - In-flight command and queued commands are discarded; strobes drop immediately.
// - Command FIFO: accept when cmd_valid & cmd_ready. cmd_ready = !full, from registered count.
//   - Push while full is never accepted, even if a pop occurs in the same cycle.
//   - Push and pop in the same cycle when not full: count unchanged.
//   - Pointers wrap modulo DEPTH; strict FIFO order.
// - All bus outputs are registered. When idle: bus_addr = 0, bus_re = 0, bus_we = 0, bus_wdata = 0.
// - FSM states and transitions:
//   - IDLE
//     - FIFO non-empty: pop; go to WR (write) or RD (read).
//   - WR
//     - bus_we = 1 for exactly one cycle with addr and wdata; go to IDLE (or VFY with macro).
//     - No response is generated.
//   - RD
//     - bus_re = 1 and bus_addr held for RD_WAIT cycles.
//     - On the last cycle, capture bus_rdata into rsp_rdata and go to RESP.
//   - RESP
//     - rsp_valid = 1; rsp_addr and rsp_rdata held stable until rsp_ready.
//     - On handshake, rsp_valid falls next edge; go to IDLE.
// - Timing:
//   - Command accepted at edge N: strobe is high after edge N+1.
//   - Read: rsp_valid rises at edge N+1+RD_WAIT.
//   - Back-to-back writes cost 2 cycles each (IDLE+WR).
// - No bus transaction is issued while in RESP; the host stalls the bus by holding rsp_ready low.
// CONFIGURATION
//   IO_WRITE_VERIFY_EN defined:
//   - After WR, go to VFY: read back the same address for RD_WAIT cycles, then go to RESP.
//   - Response: rsp_rdata = readback, rsp_err = (readback != written data).
//   - Every write yields a response.
//   IO_WRITE_VERIFY_EN undefined:
//   - No VFY state; writes produce no response; rsp_err tied 0.
// STRUCTURE
//   io_bus_defs.vh: register address constants (REG_SW_LSB = 4'h0, REG_SW_MSB = 4'h1, REG_BTN = 4'h2,
//     REG_LED_LSB = 4'h4, REG_LED_MSB = 4'h5, REG_DP = 4'h6, REG_DISP_CTRL = 4'hB, REG_DISP0..3 = 4'hC..F)
//     and FSM state encodings.
//   Sub-module io_cmd_fifo: 13-bit wide (write, addr[3:0], wdata[7:0]), DEPTH entries, full/empty/count.
// TESTING
//   1. Write addr 4 data A5 -> one cycle: bus_we = 1, bus_addr = 4, bus_wdata = A5; rsp_valid stays 0.
//   2. Read addr 0, bus_rdata = 3C, rsp_ready = 0 for 5 cycles ->
//      rsp_valid at edge N+2; rdata 3C, addr 0 held stable; clears 1 cycle after rsp_ready.
//   3. rsp_ready = 0, push a read then 5 writes (DEPTH = 4) ->
//      read stalls in RESP; 4 writes queue; cmd_ready = 0; 5th accepted only after the response drains.
//   4. Assert rst_n = 0 mid-RD -> bus_re, rsp_valid, busy = 0 without a clock edge;
//      cmd_ready = 1 after release; no stale strobe.
//   5. IO_WRITE_VERIFY_EN, write addr 6 data FF, responder returns 0F ->
//      rsp_valid with rsp_addr = 6, rsp_rdata = 0F, rsp_err = 1; matching data -> rsp_err = 0.
//   6. 10 writes to C,D,E,F,C.. with random cmd_valid gaps -> issued in order; pointer wrap; no loss or duplication.

Source files
------------

// File: rtl/io_bus_initiator_pkg.sv
// Shared definitions for the I/O register bus initiator: register map,
// FSM state encodings and the queued command record.
package io_bus_initiator_pkg;

  localparam logic [3:0] REG_SW_LSB    = 4'h0;
  localparam logic [3:0] REG_SW_MSB    = 4'h1;
  localparam logic [3:0] REG_BTN       = 4'h2;
  localparam logic [3:0] REG_LED_LSB   = 4'h4;
  localparam logic [3:0] REG_LED_MSB   = 4'h5;
  localparam logic [3:0] REG_DP        = 4'h6;
  localparam logic [3:0] REG_DISP_CTRL = 4'hB;
  localparam logic [3:0] REG_DISP0     = 4'hC;
  localparam logic [3:0] REG_DISP1     = 4'hD;
  localparam logic [3:0] REG_DISP2     = 4'hE;
  localparam logic [3:0] REG_DISP3     = 4'hF;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_VFY  = 3'd4;

  // 13-bit FIFO entry: {write, addr, wdata}
  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
  } cmd_t;

endpackage

// File: rtl/io_cmd_fifo.sv
// Command FIFO for the I/O bus initiator: DEPTH entries of cmd_t,
// full/empty/count derived from a registered occupancy counter.
module io_cmd_fifo
  import io_bus_initiator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  cmd_t                     din,
  input  logic                     pop,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // A push while full is refused even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_bus_initiator.sv
// Queued initiator for the 4-bit-address / 8-bit-data I/O register bus.
// Optional write read-back verification is enabled by defining IO_WRITE_VERIFY_EN.
module io_bus_initiator
  import io_bus_initiator_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int RD_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_addr,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [3:0] bus_addr,
  output logic       bus_re,
  output logic       bus_we,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  output logic       busy
);

  localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the source holds its payload stable while valid is high and ready is low.
  logic [2:0]           state;
  logic [WW-1:0]        wait_cnt;
  cmd_t                 head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic [$clog2(DEPTH):0] count;
`ifdef IO_WRITE_VERIFY_EN
  logic [7:0]           vfy_data;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign busy      = (count != '0) || (state != S_IDLE);

  io_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .din   ({cmd_write, cmd_addr, cmd_wdata}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      bus_addr  <= '0;
      bus_re    <= 1'b0;
      bus_we    <= 1'b0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
`ifdef IO_WRITE_VERIFY_EN
      rsp_err   <= 1'b0;
      vfy_data  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            bus_addr <= head.addr;
            if (head.write) begin
              state     <= S_WR;
              bus_we    <= 1'b1;
              bus_wdata <= head.wdata;
            end else begin
              state    <= S_RD;
              bus_re   <= 1'b1;
              wait_cnt <= WW'(RD_WAIT - 1);
            end
          end
        end
        S_WR: begin
          bus_we    <= 1'b0;
          bus_wdata <= '0;
`ifdef IO_WRITE_VERIFY_EN
          // Keep bus_addr and read the same register straight back.
          state    <= S_VFY;
          bus_re   <= 1'b1;
          wait_cnt <= WW'(RD_WAIT - 1);
          vfy_data <= bus_wdata;
`else
          state    <= S_IDLE;
          bus_addr <= '0;
`endif
        end
        S_RD, S_VFY: begin
          if (wait_cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_addr  <= bus_addr;
            rsp_rdata <= bus_rdata;
`ifdef IO_WRITE_VERIFY_EN
            rsp_err   <= (state == S_VFY) && (bus_rdata != vfy_data);
`endif
            bus_re    <= 1'b0;
            bus_addr  <= '0;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        S_RESP: begin
          // The bus stays idle until the host takes the response.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef IO_WRITE_VERIFY_EN
            rsp_err   <= 1'b0;
`endif
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed self-checking bench for io_bus_initiator (DEPTH=4, RD_WAIT=1);
// also covers IO_WRITE_VERIFY_EN when the macro is defined for both files.
module tb_io_bus_initiator;
  import io_bus_initiator_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] bus_addr;
  logic       bus_re;
  logic       bus_we;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       busy;

  int n_cmp;
  int n_fail;

  // Peripheral model: register file updated on we, optional read override.
  logic [7:0]  periph [16];
  logic        ovr_en;
  logic [7:0]  ovr_val;
  logic [11:0] obs_q[$];
  int          stamp_q[$];
  logic [11:0] exp_q[$];
  int          cyc;

  assign bus_rdata = ovr_en ? ovr_val : periph[bus_addr];

  io_bus_initiator #(.DEPTH(4), .RD_WAIT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus_addr  (bus_addr),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .busy      (busy)
  );

  // Clock and bus monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    for (int i = 0; i < 16; i++) periph[i] = 8'h00;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && bus_we) begin
      obs_q.push_back({bus_addr, bus_wdata});
      stamp_q.push_back(cyc);
      periph[bus_addr] = bus_wdata;
    end
  end

  // Driver tasks (called at a falling edge, return at a falling edge)
  task automatic push_cmd(input logic w, input logic [3:0] a, input logic [7:0] d);
    int waited;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int waited;
    waited = 0;
    while (busy && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, waited);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus_we, bus_re, bus_addr, bus_wdata} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h, required 0", {bus_we, bus_re, bus_addr, bus_wdata});
    end
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, busy, rsp_addr, rsp_rdata} !== {4'b1000, 12'h0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/valid/err/busy=%b%b%b%b addr=%h data=%h, required 1000 0 00",
               cmd_ready, rsp_valid, rsp_err, busy, rsp_addr, rsp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write;
    logic quiet;
    push_cmd(1'b1, REG_LED_LSB, 8'hA5);
    n_cmp++;
    if ({bus_we, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL write_latency: bus_we=%b busy=%b one cycle after accept, required 0 1", bus_we, busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus_we, bus_addr, bus_wdata} !== {1'b1, 4'h4, 8'hA5}) begin
      n_fail++;
      $display("FAIL write_strobe: we=%b addr=%h wdata=%h, required 1 4 a5", bus_we, bus_addr, bus_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus_we, bus_wdata} !== 9'h0) begin
      n_fail++;
      $display("FAIL write_one_cycle: we=%b wdata=%h, required 0 00", bus_we, bus_wdata);
    end
`ifndef IO_WRITE_VERIFY_EN
    n_cmp++;
    if (bus_addr !== 4'h0) begin
      n_fail++;
      $display("FAIL write_addr_idle: bus_addr=%h, required 0", bus_addr);
    end
    quiet = 1'b1;
    repeat (3) begin
      if (rsp_valid !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL write_no_rsp: rsp_valid seen high after a write, required 0");
    end
`endif
    wait_idle(20);
  endtask

  task automatic test_read;
    logic stable;
    rsp_ready = 1'b0;
    ovr_en    = 1'b1;
    ovr_val   = 8'h3C;
    push_cmd(1'b0, REG_SW_LSB, 8'h00);
    n_cmp++;
    if ({bus_re, rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL read_early: bus_re=%b rsp_valid=%b, required 0 0", bus_re, rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus_re, bus_addr, rsp_valid} !== {1'b1, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL read_strobe: re=%b addr=%h rsp_valid=%b, required 1 0 0", bus_re, bus_addr, rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_addr, rsp_rdata, rsp_err, bus_re} !== {1'b1, 4'h0, 8'h3C, 2'b00}) begin
      n_fail++;
      $display("FAIL read_rsp: valid=%b addr=%h rdata=%h err=%b re=%b, required 1 0 3c 0 0",
               rsp_valid, rsp_addr, rsp_rdata, rsp_err, bus_re);
    end
    ovr_val = 8'h00;
    stable  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || rsp_addr !== 4'h0 || bus_re || bus_we)
        stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL read_hold: response not held stable while rsp_ready=0 (rdata now %h), required 3c", rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_drain: rsp_valid=%b one cycle after rsp_ready, required 0", rsp_valid);
    end
    ovr_val = 8'h5A;
    push_cmd(1'b0, REG_BTN, 8'h00);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_addr, rsp_rdata} !== {1'b1, 4'h2, 8'h5A}) begin
      n_fail++;
      $display("FAIL read_btn: valid=%b addr=%h rdata=%h, required 1 2 5a", rsp_valid, rsp_addr, rsp_rdata);
    end
    ovr_en = 1'b0;
    wait_idle(20);
  endtask

  task automatic test_fifo_full;
    logic stalled;
    int   base;
    base      = obs_q.size();
    rsp_ready = 1'b0;
    ovr_en    = 1'b1;
    ovr_val   = 8'h77;
    push_cmd(1'b0, REG_DP, 8'h00);
    exp_q.delete();
    push_cmd(1'b1, REG_LED_LSB,   8'h11); exp_q.push_back({REG_LED_LSB,   8'h11});
    push_cmd(1'b1, REG_LED_MSB,   8'h22); exp_q.push_back({REG_LED_MSB,   8'h22});
    push_cmd(1'b1, REG_DISP_CTRL, 8'h33); exp_q.push_back({REG_DISP_CTRL, 8'h33});
    push_cmd(1'b1, REG_DISP0,     8'h44); exp_q.push_back({REG_DISP0,     8'h44});
    ovr_en    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = REG_DISP1;
    cmd_wdata = 8'h55;
    exp_q.push_back({REG_DISP1, 8'h55});
    stalled = 1'b1;
    repeat (3) begin
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || bus_we || bus_re) stalled = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (stalled !== 1'b1) begin
      n_fail++;
      $display("FAIL full_stall: cmd_ready=%b rsp_valid=%b, required 0 1 with bus idle", cmd_ready, rsp_valid);
    end
    n_cmp++;
    if ({rsp_addr, rsp_rdata} !== {REG_DP, 8'h77}) begin
      n_fail++;
      $display("FAIL full_rsp: addr=%h rdata=%h, required 6 77", rsp_addr, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, cmd_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_after_hs: rsp_valid=%b cmd_ready=%b, required 0 0", rsp_valid, cmd_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reopen: cmd_ready=%b two cycles after handshake, required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle(60);
    n_cmp++;
    if (obs_q.size() - base !== 5) begin
      n_fail++;
      $display("FAIL full_count: %0d writes issued, required 5", obs_q.size() - base);
    end
    for (int k = 0; k < 5 && base + k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[base + k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL full_order[%0d]: got %h, required %h", k, obs_q[base + k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_rd;
    logic clean;
    int   base;
    base = obs_q.size();
    push_cmd(1'b0, REG_SW_MSB,  8'h00);
    push_cmd(1'b1, REG_LED_LSB, 8'h99);
    n_cmp++;
    if (bus_re !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: bus_re=%b before reset, required 1", bus_re);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_re, bus_we, rsp_valid, busy, cmd_ready, bus_addr} !== {5'b00001, 4'h0}) begin
      n_fail++;
      $display("FAIL rst_async: re/we/valid/busy/ready=%b%b%b%b%b addr=%h, required 00001 0",
               bus_re, bus_we, rsp_valid, busy, cmd_ready, bus_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clean = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus_re || bus_we || rsp_valid || busy || !cmd_ready) clean = 1'b0;
    end
    n_cmp++;
    if (clean !== 1'b1 || obs_q.size() !== base) begin
      n_fail++;
      $display("FAIL rst_stale: clean=%b writes issued=%0d, required 1 0", clean, obs_q.size() - base);
    end
  endtask

  task automatic test_verify;
`ifdef IO_WRITE_VERIFY_EN
    int waited;
    rsp_ready = 1'b0;
    ovr_en    = 1'b1;
    ovr_val   = 8'h0F;
    push_cmd(1'b1, REG_DP, 8'hFF);
    waited = 0;
    while (!rsp_valid && waited < 10) begin @(negedge clk); waited++; end
    n_cmp++;
    if ({rsp_valid, rsp_addr, rsp_rdata, rsp_err} !== {1'b1, 4'h6, 8'h0F, 1'b1}) begin
      n_fail++;
      $display("FAIL vfy_bad: valid=%b addr=%h rdata=%h err=%b, required 1 6 0f 1",
               rsp_valid, rsp_addr, rsp_rdata, rsp_err);
    end
    ovr_en    = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    push_cmd(1'b1, REG_DP, 8'hAA);
    waited = 0;
    while (!rsp_valid && waited < 10) begin @(negedge clk); waited++; end
    n_cmp++;
    if ({rsp_valid, rsp_addr, rsp_rdata, rsp_err} !== {1'b1, 4'h6, 8'hAA, 1'b0}) begin
      n_fail++;
      $display("FAIL vfy_good: valid=%b addr=%h rdata=%h err=%b, required 1 6 aa 0",
               rsp_valid, rsp_addr, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
`else
    logic quiet;
    push_cmd(1'b1, REG_DP, 8'hFF);
    quiet = 1'b1;
    repeat (4) begin
      if (rsp_valid || rsp_err) quiet = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL no_vfy: rsp_valid/rsp_err seen high after a write, required 0");
    end
`endif
    wait_idle(20);
  endtask

  task automatic test_back_to_back;
    int base;
    int sbase;
    int gap;
    base  = obs_q.size();
    sbase = stamp_q.size();
`ifdef IO_WRITE_VERIFY_EN
    gap = 4;
`else
    gap = 2;
`endif
    exp_q.delete();
    push_cmd(1'b1, REG_DISP0, 8'h01); exp_q.push_back({REG_DISP0, 8'h01});
    push_cmd(1'b1, REG_DISP1, 8'h02); exp_q.push_back({REG_DISP1, 8'h02});
    push_cmd(1'b1, REG_DISP2, 8'h03); exp_q.push_back({REG_DISP2, 8'h03});
    for (int i = 0; i < 10; i++) begin
      logic [3:0] a;
      logic [7:0] d;
      a = 4'hC + 4'(i % 4);
      d = 8'h30 + 8'(i);
      push_cmd(1'b1, a, d);
      exp_q.push_back({a, d});
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(200);
    n_cmp++;
    if (stamp_q.size() - sbase < 3 || stamp_q[sbase + 1] - stamp_q[sbase] !== gap ||
        stamp_q[sbase + 2] - stamp_q[sbase + 1] !== gap) begin
      n_fail++;
      $display("FAIL b2b_spacing: write strobes not %0d cycles apart", gap);
    end
    n_cmp++;
    if (obs_q.size() - base !== 13) begin
      n_fail++;
      $display("FAIL order_count: %0d writes issued, required 13", obs_q.size() - base);
    end
    for (int k = 0; k < 13 && base + k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[base + k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL order[%0d]: got %h, required %h", k, obs_q[base + k], exp_q[k]);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 4'h0;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b1;
    ovr_en    = 1'b0;
    ovr_val   = 8'h00;
    test_reset;
    test_write;
    test_read;
    test_fifo_full;
    test_reset_mid_rd;
    test_verify;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
